// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg
// Shared definitions for the execute-stage branch controller:
//   - comparator result encodings (CMP_GT, CMP_LT, CMP_EQ, CMP_INV)
//   - branch funct3 codes (F3_BEQ .. F3_BGEU)
//   - controller state encoding (IDLE, REDIRECT, KILL)
package branch_ctrl_pkg;

  // Comparator result encodings
  localparam logic [1:0] CMP_GT  = 2'b00;
  localparam logic [1:0] CMP_LT  = 2'b01;
  localparam logic [1:0] CMP_EQ  = 2'b10;
  localparam logic [1:0] CMP_INV = 2'b11;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Controller states
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REDIRECT = 2'b01,
    KILL     = 2'b10
  } state_t;

endpackage

// File: rtl/branch_decide.sv
// branch_decide
// Purely combinational branch condition decode.
// Ports:
//   funct3     in  3  branch funct3
//   cmp_result in  2  comparator result (00 a>b, 01 a<b, 10 a==b, 11 invalid)
//   taken      out 1  branch condition holds
//   illegal    out 1  funct3 is not a defined branch (010/011)
module branch_decide
  import branch_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] cmp_result,
  output logic       taken,
  output logic       illegal
);

  logic eq;
  logic lt;

  // An invalid comparator result decodes as neither equal nor less-than.
  assign eq = (cmp_result == CMP_EQ);
  assign lt = (cmp_result == CMP_LT);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:            taken = eq;
      F3_BNE:            taken = !eq;
      F3_BLT, F3_BLTU:   taken = lt;
      F3_BGE, F3_BGEU:   taken = !lt;
      default:           illegal = 1'b1;  // 010 / 011
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl
// Execute-stage branch/jump resolution controller. Resolves the branch in EX,
// issues a handshaked PC redirect to fetch, then holds flush for a window of
// FLUSH_CYCLES pipeline-advance cycles to kill wrong-path instructions.
// Optional macro BRANCH_CTRL_PERF_EN enables the three performance counters;
// without it the perf ports read 0 and no counter flops exist.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid, ex_stall       EX occupancy / pipeline hold
//   ex_is_branch/jal/jalr    instruction class
//   ex_funct3, ex_target     branch funct3, computed target
//   cmp_result, cmp_unsigned shared comparator result / signedness select
//   redirect_valid/ready/pc  redirect handshake to fetch
//   flush                    kill IF/ID contents
//   misalign, illegal_br     one-cycle pulses, one cycle after resolve
//   perf_*                   performance counters
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_target,
  input  logic [1:0]  cmp_result,
  output logic        cmp_unsigned,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        misalign,
  output logic        illegal_br,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_taken,
  output logic [31:0] perf_flush_cyc
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state_reg, state_next;
  logic [2:0]  kill_cnt_reg, kill_cnt_next;
  logic [31:0] redirect_pc_reg, redirect_pc_next;
  logic        misalign_reg, misalign_next;
  logic        illegal_reg, illegal_next;

  logic        cond_taken;
  logic        cond_illegal;
  logic        resolve;
  logic        taken;
  logic [31:0] target;

  assign cmp_unsigned = ex_funct3[1];

  branch_decide u_decide (
    .funct3     (ex_funct3),
    .cmp_result (cmp_result),
    .taken      (cond_taken),
    .illegal    (cond_illegal)
  );

  // Only IDLE resolves; anything in EX during REDIRECT/KILL is wrong-path.
  assign resolve = ex_valid & !ex_stall & (state_reg == IDLE)
                 & (ex_is_branch | ex_is_jal | ex_is_jalr);
  assign taken   = ex_is_jal | ex_is_jalr | (ex_is_branch & cond_taken);
  assign target  = {ex_target[31:1], ex_target[0] & !ex_is_jalr};

  always_comb begin
    state_next       = state_reg;
    kill_cnt_next    = kill_cnt_reg;
    redirect_pc_next = redirect_pc_reg;
    misalign_next    = resolve & taken & (target[1:0] != 2'b00);
    illegal_next     = resolve & ex_is_branch & cond_illegal;
    case (state_reg)
      IDLE: begin
        if (resolve && taken) begin
          redirect_pc_next = target;
          state_next       = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          kill_cnt_next = FLUSH_LOAD;
          state_next    = KILL;
        end
      end
      KILL: begin
        // The window counts advancing cycles only; stalled cycles keep
        // the same wrong-path instructions in flight.
        if (!ex_stall) begin
          kill_cnt_next = kill_cnt_reg - 3'd1;
          if (kill_cnt_reg <= 3'd1) begin
            kill_cnt_next = 3'd0;
            state_next    = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      kill_cnt_reg    <= 3'd0;
      redirect_pc_reg <= RESET_PC;
      misalign_reg    <= 1'b0;
      illegal_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      kill_cnt_reg    <= kill_cnt_next;
      redirect_pc_reg <= redirect_pc_next;
      misalign_reg    <= misalign_next;
      illegal_reg     <= illegal_next;
    end
  end

  assign redirect_valid = (state_reg == REDIRECT);
  assign flush          = (state_reg != IDLE);
  assign redirect_pc    = redirect_pc_reg;
  assign misalign       = misalign_reg;
  assign illegal_br     = illegal_reg;

`ifdef BRANCH_CTRL_PERF_EN
  logic [31:0] perf_branches_reg;
  logic [31:0] perf_taken_reg;
  logic [31:0] perf_flush_cyc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches_reg  <= '0;
      perf_taken_reg     <= '0;
      perf_flush_cyc_reg <= '0;
    end else begin
      if (resolve)         perf_branches_reg  <= perf_branches_reg + 32'd1;
      if (resolve && taken) perf_taken_reg    <= perf_taken_reg + 32'd1;
      if (flush)           perf_flush_cyc_reg <= perf_flush_cyc_reg + 32'd1;
    end
  end

  assign perf_branches  = perf_branches_reg;
  assign perf_taken     = perf_taken_reg;
  assign perf_flush_cyc = perf_flush_cyc_reg;
`else
  assign perf_branches  = '0;
  assign perf_taken     = '0;
  assign perf_flush_cyc = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl
// Directed scenarios followed by random traffic, every cycle checked against
// a behavioural model built from the branch rules (pending-redirect flag,
// remaining kill cycles, expected pulses and counters).
module tb_branch_ctrl;

  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_target;
  logic [1:0]  cmp_result;
  logic        cmp_unsigned;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush, misalign, illegal_br;
  logic [31:0] perf_branches, perf_taken, perf_flush_cyc;

  always #5 clk = ~clk;

  branch_ctrl #(.FLUSH_CYCLES(FLUSH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_funct3      (ex_funct3),
    .ex_target      (ex_target),
    .cmp_result     (cmp_result),
    .cmp_unsigned   (cmp_unsigned),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .misalign       (misalign),
    .illegal_br     (illegal_br),
    .perf_branches  (perf_branches),
    .perf_taken     (perf_taken),
    .perf_flush_cyc (perf_flush_cyc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Behavioural model
  bit          m_wait_ready;   // redirect issued, waiting for fetch
  int          m_kill_left;    // advancing cycles of wrong-path still to kill
  logic [31:0] m_pc;
  bit          m_misalign, m_illegal;
  logic [31:0] m_pb, m_pt, m_pf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_holds(input logic [2:0] f3, input logic [1:0] c);
    bit eq = (c == 2'b10);
    bit lt = (c == 2'b01);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic check_outputs();
    bit exp_flush = m_wait_ready || (m_kill_left > 0);
    chk("cmp_unsigned", 32'(cmp_unsigned), 32'(ex_funct3[1]));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_wait_ready));
    chk("flush", 32'(flush), 32'(exp_flush));
    chk("redirect_pc", redirect_pc, m_pc);
    chk("misalign", 32'(misalign), 32'(m_misalign));
    chk("illegal_br", 32'(illegal_br), 32'(m_illegal));
`ifdef BRANCH_CTRL_PERF_EN
    chk("perf_branches", perf_branches, m_pb);
    chk("perf_taken", perf_taken, m_pt);
    chk("perf_flush_cyc", perf_flush_cyc, m_pf);
`else
    chk("perf_branches", perf_branches, 32'd0);
    chk("perf_taken", perf_taken, 32'd0);
    chk("perf_flush_cyc", perf_flush_cyc, 32'd0);
`endif
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit busy, tk;
    logic [31:0] t;
    if (rst) begin
      m_wait_ready = 0; m_kill_left = 0; m_pc = 32'h0;
      m_misalign = 0; m_illegal = 0; m_pb = 0; m_pt = 0; m_pf = 0;
      return;
    end
    busy = m_wait_ready || (m_kill_left > 0);
    m_misalign = 0;
    m_illegal  = 0;
    if (busy) m_pf = m_pf + 1;
    if (m_wait_ready) begin
      if (redirect_ready) begin
        m_wait_ready = 0;
        m_kill_left  = FLUSH;
      end
    end else if (m_kill_left > 0) begin
      if (!ex_stall) m_kill_left = m_kill_left - 1;
    end else if (ex_valid && !ex_stall && (ex_is_branch || ex_is_jal || ex_is_jalr)) begin
      m_pb = m_pb + 1;
      tk = ex_is_jal || ex_is_jalr || (ex_is_branch && cond_holds(ex_funct3, cmp_result));
      m_illegal = ex_is_branch && (ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
      t = ex_target;
      if (ex_is_jalr) t[0] = 1'b0;
      if (tk) begin
        m_pt = m_pt + 1;
        m_pc = t;
        m_wait_ready = 1;
        m_misalign = (t[1:0] != 2'b00);
      end
      n_txn++;
      $display("txn %0d: br=%0b jal=%0b jalr=%0b f3=%0d cmp=%0d target=%h taken=%0b",
               n_txn, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3, cmp_result, t, tk);
    end
  endtask

  // One cycle: inputs already driven shortly after the previous edge.
  task automatic cyc();
    #2;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input bit st, input bit br, input bit jal, input bit jalr,
                       input logic [2:0] f3, input logic [1:0] c, input logic [31:0] tgt,
                       input bit rdy);
    ex_valid = v; ex_stall = st; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; cmp_result = c; ex_target = tgt; redirect_ready = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 3'd0, 2'd0, 32'h0, rdy);
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 3'd0, 2'd0, 32'h0, 0);
    @(posedge clk); model_edge(); #1;
    cyc();
    rst = 1'b0;

    // Taken BEQ, immediate accept: 3 flush cycles
    drive(1, 0, 1, 0, 0, 3'd0, 2'b10, 32'h100, 1); cyc();
    #2; chk("beq_redirect_pc", redirect_pc, 32'h100); #0;
    idle(5, 1);

    // BLTU not taken
    drive(1, 0, 1, 0, 0, 3'd6, 2'b00, 32'h400, 1); cyc();
    idle(2, 1);

    // JALR to misaligned target
    drive(1, 0, 0, 0, 1, 3'd0, 2'b11, 32'h203, 1); cyc();
    #2; chk("jalr_pc", redirect_pc, 32'h202); chk("jalr_misalign", 32'(misalign), 32'd1);
    idle(5, 1);

    // Taken BNE, fetch refuses for 4 cycles while a JAL sits in EX
    drive(1, 0, 1, 0, 0, 3'd1, 2'b00, 32'h800, 0); cyc();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 0, 3'd0, 2'd0, 32'hC00, 0); cyc();
    end
    idle(5, 1);

    // Taken branch, stall held 3 cycles mid kill window
    rst = 1'b1; idle(1, 1); rst = 1'b0;
    drive(1, 0, 1, 0, 0, 3'd5, 2'b00, 32'h40, 1); cyc();
    idle(1, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 3'd0, 2'd0, 32'h0, 1); cyc();
    end
    idle(4, 1);

    // Illegal funct3
    drive(1, 0, 1, 0, 0, 3'd3, 2'b10, 32'h60, 1); cyc();
    idle(2, 1);

    // Reset during the kill window
    drive(1, 0, 0, 1, 0, 3'd0, 2'd0, 32'h1234, 1); cyc();
    idle(1, 1);
    rst = 1'b1; idle(1, 1); rst = 1'b0;
    idle(2, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int kind = $urandom_range(0, 4);
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            kind == 0 || kind == 1, kind == 2, kind == 3,
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 2) != 0);
      cyc();
    end
    rst = 1'b0;
    idle(3, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
